// File: rtl/bcd_counter_7seg_mux_if.sv
// Control and display bundle for the multiplexed BCD counter.
// The master drives count controls; the slave returns the count and display lines.
interface bcd_counter_7seg_mux_if #(
   parameter int DIGITS = 4
);
   // load is a single-cycle strobe: there is no back-pressure, and every cycle
   // it is high replaces the count. en and up_dn are level-sensitive.
   logic                  en;
   logic                  up_dn;
   logic                  load;
   logic [4*DIGITS-1:0]   load_val;
   logic [4*DIGITS-1:0]   count;
   logic                  wrap;
   logic [7:0]            led;
   logic [DIGITS-1:0]     anode;

   modport master (
      output en, up_dn, load, load_val,
      input  count, wrap, led, anode
   );

   modport slave (
      input  en, up_dn, load, load_val,
      output count, wrap, led, anode
   );
endinterface

// File: rtl/bcd_counter_7seg_mux.sv
// Prescaled up/down BCD counter with parallel load, driving a time-multiplexed
// common-anode seven-segment display (active-low segments and anodes).
module bcd_counter_7seg_mux #(
   parameter int DIGITS      = 4,
   parameter int TICK_DIV    = 50000000,
   parameter int REFRESH_DIV = 100000
) (
   input  logic                   clk,
   input  logic                   rst,
   bcd_counter_7seg_mux_if.slave  bus
);

   localparam int CW = 4 * DIGITS;
   localparam int TW = (TICK_DIV    > 1) ? $clog2(TICK_DIV)    : 1;
   localparam int RW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
   localparam int DW = (DIGITS      > 1) ? $clog2(DIGITS)      : 1;

   localparam logic [TW-1:0] TICK_LAST = TW'(TICK_DIV - 1);
   localparam logic [RW-1:0] REF_LAST  = RW'(REFRESH_DIV - 1);
   localparam logic [DW-1:0] IDX_LAST  = DW'(DIGITS - 1);

   logic [TW-1:0]     r_tick_cnt;
   logic [RW-1:0]     r_ref_cnt;
   logic [DW-1:0]     r_digit_idx;
   logic [CW-1:0]     r_count;
   logic              r_wrap;
   logic [7:0]        r_led;
   logic [DIGITS-1:0] r_anode;

   logic              w_tick;
   logic              w_ref_term;
   logic              w_roll;
   logic [CW-1:0]     w_count_step;
   logic [CW-1:0]     w_load_clamped;
   logic [CW-1:0]     w_count_nxt;
   logic [DW-1:0]     w_idx_nxt;
   logic [3:0]        w_show_digit;
   logic [6:0]        w_seg;

   assign w_tick     = bus.en && (r_tick_cnt == TICK_LAST);
   assign w_ref_term = (r_ref_cnt == REF_LAST);

   // Ripple carry/borrow: w_roll ends high only when every digit rolled over.
   always_comb begin : step_logic
      logic       c;
      logic [3:0] d;
      w_count_step = r_count;
      c = 1'b1;
      d = 4'd0;
      for (int i = 0; i < DIGITS; i++) begin
         d = r_count[4*i +: 4];
         if (c) begin
            if (bus.up_dn) begin
               if (d >= 4'd9) begin
                  w_count_step[4*i +: 4] = 4'd0;
               end else begin
                  w_count_step[4*i +: 4] = d + 4'd1;
                  c = 1'b0;
               end
            end else begin
               if (d == 4'd0) begin
                  w_count_step[4*i +: 4] = 4'd9;
               end else begin
                  w_count_step[4*i +: 4] = d - 4'd1;
                  c = 1'b0;
               end
            end
         end
      end
      w_roll = c;
   end

   always_comb begin : load_clamp
      w_load_clamped = bus.load_val;
      for (int i = 0; i < DIGITS; i++) begin
         if (bus.load_val[4*i +: 4] > 4'd9) begin
            w_load_clamped[4*i +: 4] = 4'd9;
         end
      end
   end

   always_comb begin : count_select
      if (bus.load) begin
         w_count_nxt = w_load_clamped;
      end else if (w_tick) begin
         w_count_nxt = w_count_step;
      end else begin
         w_count_nxt = r_count;
      end
   end

   // A single-digit display never scans, so the index is pinned at zero.
   always_comb begin : idx_select
      w_idx_nxt = r_digit_idx;
      if ((DIGITS > 1) && w_ref_term) begin
         if (r_digit_idx == IDX_LAST) begin
            w_idx_nxt = '0;
         end else begin
            w_idx_nxt = r_digit_idx + 1'b1;
         end
      end
   end

   // led and anode are built from next-state values so both registers
   // always describe the count and index held in the same cycle.
   always_comb begin : digit_mux
      w_show_digit = 4'd0;
      for (int i = 0; i < DIGITS; i++) begin
         if (w_idx_nxt == DW'(i)) begin
            w_show_digit = w_count_nxt[4*i +: 4];
         end
      end
   end

   always_comb begin : seg_decode
      case (w_show_digit)
         4'd0:    w_seg = 7'h40;
         4'd1:    w_seg = 7'h79;
         4'd2:    w_seg = 7'h24;
         4'd3:    w_seg = 7'h30;
         4'd4:    w_seg = 7'h19;
         4'd5:    w_seg = 7'h12;
         4'd6:    w_seg = 7'h02;
         4'd7:    w_seg = 7'h78;
         4'd8:    w_seg = 7'h00;
         4'd9:    w_seg = 7'h10;
         default: w_seg = 7'h7F;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_tick_cnt  <= '0;
         r_ref_cnt   <= '0;
         r_digit_idx <= '0;
         r_count     <= '0;
         r_wrap      <= 1'b0;
         r_anode     <= ~DIGITS'(1);
         r_led       <= 8'hC0;
      end else begin
         r_count <= w_count_nxt;
         r_wrap  <= !bus.load && w_tick && w_roll;

         if (bus.load || w_tick) begin
            r_tick_cnt <= '0;
         end else if (bus.en) begin
            r_tick_cnt <= r_tick_cnt + 1'b1;
         end

         r_ref_cnt   <= w_ref_term ? '0 : r_ref_cnt + 1'b1;
         r_digit_idx <= w_idx_nxt;
         r_anode     <= ~(DIGITS'(1) << w_idx_nxt);
         r_led       <= {1'b1, w_seg};
      end
   end

   assign bus.count = r_count;
   assign bus.wrap  = r_wrap;
   assign bus.led   = r_led;
   assign bus.anode = r_anode;

endmodule
